aes_key_schedule: RTL and testbench

- Sequential AES-128 key schedule controller built around the existing single-round key expansion stage.
- Accepts a 128-bit cipher key over a valid/ready handshake.
- Iterates the expansion stage once per cycle to produce round keys 1..10 and stores all 11 round keys (0..10) in an internal register file.
- The downstream cipher round datapath reads keys by index through a registered read port.

---
 rtl/aes_key_schedule_if.sv | 21 ++
 rtl/aes_key_schedule.sv | 106 ++++++++++
 tb/tb_aes_key_schedule.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_schedule_if.sv
// Key-load handshake and round-key read port between the AES key schedule
// and the cipher datapath that feeds it keys and reads round keys back.
interface aes_key_schedule_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;

  modport master (
    output key_in, key_valid, rk_addr,
    input  key_ready, busy, keys_valid, rk_data
  );

  modport slave (
    input  key_in, key_valid, rk_addr,
    output key_ready, busy, keys_valid, rk_data
  );
endinterface

// File: rtl/aes_key_schedule.sv
// AES-128 key schedule: one expansion stage iterated once per cycle fills an
// 11-entry round-key register file, read back through a registered port.
module aes_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input logic              CLOCK_50,
  input logic              rst_n,
  aes_key_schedule_if.slave ks
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [3:0] LAST_R  = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] MAX_IDX = 4'(NUM_ROUNDS);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [1:0]   state;
  logic [3:0]   r;
  logic [127:0] rk [0:NUM_ROUNDS];
  logic [127:0] cur_key;
  logic [127:0] nxt_key;
  logic         accept;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k,
                                              input logic [3:0]   round);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rcon(round), 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    key_expand = {n0, n1, n2, n3};
  endfunction

  assign ks.key_ready  = (state != ST_EXPAND);
  assign ks.busy       = (state == ST_EXPAND);
  assign ks.keys_valid = (state == ST_DONE);
  assign accept        = ks.key_valid && ks.key_ready;

  // The single expansion stage always works on the key of the current round.
  assign cur_key = rk[r];
  assign nxt_key = key_expand(cur_key, r);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      r     <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
    end else if (state == ST_EXPAND) begin
      rk[r + 4'd1] <= nxt_key;
      r            <= r + 4'd1;
      if (r == LAST_R) state <= ST_DONE;
    end else if (accept) begin
      rk[0] <= ks.key_in;
      r     <= '0;
      state <= ST_EXPAND;
    end
  end

  // Read port samples the register file before this edge's write lands.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) ks.rk_data <= '0;
    else        ks.rk_data <= (ks.rk_addr <= MAX_IDX) ? rk[ks.rk_addr] : '0;
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule against a FIPS-197 style reference
// that derives the S-box from GF(2^8) inversion and expands keys word by word.
module tb_aes_key_schedule;

  logic CLOCK_50 = 1'b0;
  logic rst_n    = 1'b0;
  int   cyc      = 0;

  aes_key_schedule_if bus();

  aes_key_schedule dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .ks       (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int           due;
    bit           is_data;
    logic [127:0] val;
    string        name;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [7:0]   sbox_ref [256];
  logic [7:0]   rcon_ref [11];
  logic [127:0] mem  [11];
  logic [127:0] pend [11];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic void build_tables();
    logic [7:0] inv, rc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(x));
      end
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc = 8'h01;
    rcon_ref[0] = 8'h00;
    for (int i = 1; i < 11; i++) begin
      rcon_ref[i] = rc;
      rc = gmul(rc, 8'h02);
    end
  endfunction

  function automatic void fill_sched(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
        t = t ^ {rcon_ref[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) pend[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic expect_status(input int due, input logic rdy, input logic bsy,
                               input logic kv, input string name);
    exp_t e;
    e.due = due; e.is_data = 1'b0; e.val = {125'h0, rdy, bsy, kv}; e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_data(input int due, input logic [127:0] v, input string name);
    exp_t e;
    e.due = due; e.is_data = 1'b1; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  always @(negedge CLOCK_50) begin
    int i;
    logic [127:0] got;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        got = sb[i].is_data ? bus.rk_data
                            : {125'h0, bus.key_ready, bus.busy, bus.keys_valid};
        n_tests++;
        if (got !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%032h expected=%032h",
                   sb[i].name, cyc, got, sb[i].val);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic read(input logic [3:0] addr, input logic [127:0] v, input string name);
    bus.rk_addr = addr;
    expect_data(cyc + 1, v, name);
    step();
  endtask

  task automatic accept(input logic [127:0] key, input bit track);
    bus.key_in    = key;
    bus.key_valid = 1'b1;
    fill_sched(key);
    if (track) begin
      for (int k = 1; k <= 10; k++) expect_status(cyc + k, 1'b0, 1'b1, 1'b0, "expanding");
      expect_status(cyc + 11, 1'b1, 1'b0, 1'b1, "done_after_10");
    end
    step();
    bus.key_valid = 1'b0;
  endtask

  task automatic finish_expand(input int steps_left, input bit noise);
    for (int k = 0; k < steps_left; k++) begin
      if (noise) begin
        bus.key_valid = 1'($urandom_range(0, 1));
        bus.key_in    = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
    end
    bus.key_valid = 1'b0;
    for (int k = 0; k < 11; k++) mem[k] = pend[k];
  endtask

  task automatic read_all(input string name);
    for (int k = 0; k < 11; k++) read(4'(k), mem[k], name);
    read(4'($urandom_range(11, 15)), 128'h0, "rand_oor");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k;
    bus.key_in = '0; bus.key_valid = 1'b0; bus.rk_addr = 4'd0;
    build_tables();
    for (int i = 0; i < 11; i++) mem[i] = '0;

    // Reset held low for three cycles, then idle with no key offered
    for (int i = 0; i < 3; i++) begin
      step();
      expect_status(cyc, 1'b1, 1'b0, 1'b0, "reset_status");
      expect_data(cyc, 128'h0, "reset_rk_data");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_status(cyc + 1, 1'b1, 1'b0, 1'b0, "idle_status");
      read(4'(i), 128'h0, "idle_read");
    end

    // FIPS-197 known answer, with a key offered during EXPAND cycle 3
    accept(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    finish_expand(2, 1'b0);
    bus.key_in    = 128'h000102030405060708090a0b0c0d0e0f;
    bus.key_valid = 1'b1;
    expect_status(cyc, 1'b0, 1'b1, 1'b0, "backpressure_ready");
    finish_expand(8, 1'b0);
    read(4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "kat_rk0");
    read(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "kat_rk1");
    read(4'd2,  128'hf2c295f27a96b9435935807a7359f67f, "kat_rk2");
    read(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "kat_rk10");
    read_all("kat_model");
    read(4'd11, 128'h0, "oor_11");
    read(4'd15, 128'h0, "oor_15");

    // Re-key from DONE with a same-edge read that must see the old key
    bus.rk_addr = 4'd10;
    expect_data(cyc + 1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "rekey_preread");
    accept(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    finish_expand(10, 1'b0);
    read(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "rekey_rk10");

    // Reset in the middle of an expansion
    accept({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    for (int i = 0; i < 11; i++) mem[i] = '0;
    expect_status(cyc, 1'b1, 1'b0, 1'b0, "midreset_status");
    expect_data(cyc, 128'h0, "midreset_rk_data");
    step();
    rst_n = 1'b1;
    expect_status(cyc + 1, 1'b1, 1'b0, 1'b0, "post_reset_status");
    read(4'd1, 128'h0, "post_reset_rk1");
    expect_status(cyc + 1, 1'b1, 1'b0, 1'b0, "post_reset_idle");
    read(4'd0, 128'h0, "post_reset_rk0");

    // Random keys with ignored key_valid noise during expansion
    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      accept(k, 1'b1);
      finish_expand(10, 1'b1);
      read_all("rand_key");
    end

    repeat (3) step();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
